// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// Instruction fields and memory status come in; mux selects and strobes go out.
interface multicycle_controller_if;
    logic [5:0] opCode;
    logic [5:0] func;
    logic       zero;
    logic       memReady;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] regDst;
    logic [1:0] regSrc;
    logic       regWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       instrDone;
    logic       illegal;

    modport master (
        input  opCode, func, zero, memReady,
        output pcWrite, pcSrc, iorD, memRead, memWrite, irWrite,
        output regDst, regSrc, regWrite, ALUSrcA, ALUSrcB, ALUOp,
        output instrDone, illegal
    );

    modport slave (
        output opCode, func, zero, memReady,
        input  pcWrite, pcSrc, iorD, memRead, memWrite, irWrite,
        input  regDst, regSrc, regWrite, ALUSrcA, ALUSrcB, ALUOp,
        input  instrDone, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back
// sequencing over a shared, variable-latency memory port.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          rstN,
    multicycle_controller_if.master       bus
);
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_SLT = 6'd42;
    localparam logic [5:0] FN_JR  = 6'd8;

    typedef enum logic [3:0] {
        INIT, FETCH, DECODE, REXEC, RWB, IEXEC, IWB, MADDR,
        MRD, LWB, MWR, BRANCH, JMP, JALS, JRS
    } state_t;

    state_t state, next;

    logic is_rtype, is_ralu, is_jr, is_ialu;
    logic is_mem, is_br, is_j, is_jal;

    always_comb begin
        is_rtype = (bus.opCode == OP_RTYPE);
        is_ralu  = is_rtype && (bus.func == FN_ADD ||
                                bus.func == FN_SUB ||
                                bus.func == FN_SLT);
        is_jr    = is_rtype && (bus.func == FN_JR);
        is_ialu  = (bus.opCode == OP_ADDI) || (bus.opCode == OP_SLTI);
        is_mem   = (bus.opCode == OP_LW) || (bus.opCode == OP_SW);
        is_br    = (bus.opCode == OP_BEQ) || (bus.opCode == OP_BNE);
        is_j     = (bus.opCode == OP_J);
        is_jal   = (bus.opCode == OP_JAL);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= INIT;
        else       state <= next;
    end

    always_comb begin
        next          = state;
        bus.pcWrite   = 1'b0;
        bus.pcSrc     = 2'd0;
        bus.iorD      = 1'b0;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.irWrite   = 1'b0;
        bus.regDst    = 2'd0;
        bus.regSrc    = 2'd0;
        bus.regWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'd0;
        bus.ALUOp     = 2'd0;
        bus.instrDone = 1'b0;
        bus.illegal   = 1'b0;

        unique case (state)
            INIT: next = FETCH;
            FETCH: begin
                bus.memRead = 1'b1;
                bus.ALUSrcB = 2'd1;
                if (bus.memReady) begin
                    bus.irWrite = 1'b1;
                    bus.pcWrite = 1'b1;
                    next        = DECODE;
                end
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                bus.ALUSrcB = 2'd3;
                unique case (1'b1)
                    is_ralu: next = REXEC;
                    is_jr:   next = JRS;
                    is_ialu: next = IEXEC;
                    is_mem:  next = MADDR;
                    is_br:   next = BRANCH;
                    is_j:    next = JMP;
                    is_jal:  next = JALS;
                    default: begin
                        bus.illegal   = 1'b1;
                        bus.instrDone = 1'b1;
                        next          = FETCH;
                    end
                endcase
            end
            REXEC: begin
                bus.ALUSrcA = 1'b1;
                if (bus.func == FN_SUB)      bus.ALUOp = 2'd1;
                else if (bus.func == FN_SLT) bus.ALUOp = 2'd2;
                next = RWB;
            end
            RWB: begin
                bus.regWrite  = 1'b1;
                bus.regDst    = 2'd1;
                bus.regSrc    = 2'd2;
                bus.instrDone = 1'b1;
                next          = FETCH;
            end
            IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                if (bus.opCode == OP_SLTI) bus.ALUOp = 2'd2;
                next = IWB;
            end
            IWB: begin
                bus.regWrite  = 1'b1;
                bus.regSrc    = 2'd2;
                bus.instrDone = 1'b1;
                next          = FETCH;
            end
            MADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                next = (bus.opCode == OP_LW) ? MRD : MWR;
            end
            MRD: begin
                bus.memRead = 1'b1;
                bus.iorD    = 1'b1;
                if (bus.memReady) next = LWB;
            end
            LWB: begin
                bus.regWrite  = 1'b1;
                bus.regSrc    = 2'd1;
                bus.instrDone = 1'b1;
                next          = FETCH;
            end
            MWR: begin
                bus.memWrite = 1'b1;
                bus.iorD     = 1'b1;
                if (bus.memReady) begin
                    bus.instrDone = 1'b1;
                    next          = FETCH;
                end
            end
            BRANCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUOp     = 2'd1;
                bus.pcSrc     = 2'd1;
                bus.pcWrite   = (bus.opCode == OP_BNE) ? ~bus.zero : bus.zero;
                bus.instrDone = 1'b1;
                next          = FETCH;
            end
            JMP: begin
                bus.pcWrite   = 1'b1;
                bus.pcSrc     = 2'd2;
                bus.instrDone = 1'b1;
                next          = FETCH;
            end
            JALS: begin
                // PC already holds PC+4, which is the link value.
                bus.pcWrite   = 1'b1;
                bus.pcSrc     = 2'd2;
                bus.regWrite  = 1'b1;
                bus.regDst    = 2'd2;
                bus.instrDone = 1'b1;
                next          = FETCH;
            end
            JRS: begin
                bus.pcWrite   = 1'b1;
                bus.pcSrc     = 2'd3;
                bus.instrDone = 1'b1;
                next          = FETCH;
            end
            default: next = INIT;
        endcase
    end
endmodule
